// File: rtl/pkg_cpu.sv
// Shared CPU encodings.
// Data access size used on CPU-side and memory-side buses.
package pkg_cpu;

    localparam logic CPU_DATA_ACC_SZ_8  = 1'b0;
    localparam logic CPU_DATA_ACC_SZ_16 = 1'b1;

endpackage

// File: rtl/pkg_mem_arb.sv
// Memory arbiter types and constants.
// FSM states, requester indices, lock depth, legality helper.
package pkg_mem_arb;

    import pkg_cpu::*;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // Grants covered by one lock (32-bit fetch = two halves).
    localparam logic [1:0] LOCK_DEPTH = 2'd2;

    // 16-bit writes and misaligned 16-bit accesses are refused.
    function automatic logic acc_legal(
        input logic we,
        input logic sz,
        input logic a0
    );
        return !((sz == CPU_DATA_ACC_SZ_16) && (we || a0));
    endfunction

endpackage

// File: rtl/spcpu_arb_picker.sv
// Winner selection for the memory arbiter.
// Lock owner first, then round-robin on last grant.
module spcpu_arb_picker
    import pkg_mem_arb::*;
(
    input  logic [1:0] i_cand,
    input  logic       i_last_grant,
    input  logic       i_lock_act,
    input  logic       i_lock_idx,
    output logic       o_winner,
    output logic       o_gnt_valid,
    output logic       o_lock_hit
);

    // Pick the locked owner if it is asking, else alternate.
    always_comb begin
        o_winner    = REQ_CPU;
        o_gnt_valid = |i_cand;
        o_lock_hit  = 1'b0;
        if (i_lock_act && i_cand[i_lock_idx]) begin
            o_winner   = i_lock_idx;
            o_lock_hit = 1'b1;
        end else if (&i_cand) begin
            o_winner = ~i_last_grant;
        end else if (i_cand[REQ_DBG]) begin
            o_winner = REQ_DBG;
        end
    end

endmodule

// File: rtl/spcpu_mem_arbiter.sv
// Two-requester memory arbiter (CPU, debug/loader).
// Fixed 3-cycle transaction: grant, issue, response.
module spcpu_mem_arbiter
    import pkg_cpu::*;
    import pkg_mem_arb::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic [15:0] req0_addr,
    input  logic        req0_we,
    input  logic        req0_acc_sz,
    input  logic [15:0] req0_wdata,
    input  logic        req0_lock,
    output logic        req0_ready,
    output logic        req0_rvalid,
    output logic [15:0] req0_rdata,
    output logic        req0_err,

    input  logic        req1_valid,
    input  logic [15:0] req1_addr,
    input  logic        req1_we,
    input  logic        req1_acc_sz,
    input  logic [15:0] req1_wdata,
    input  logic        req1_lock,
    output logic        req1_ready,
    output logic        req1_rvalid,
    output logic [15:0] req1_rdata,
    output logic        req1_err,

    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic        mem_acc_sz,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    arb_state_e  r_state;
    logic        r_owner;
    logic        r_we;
    logic        r_last_grant;
    logic [1:0]  r_lock_left;
    logic [15:0] r_mem_addr;
    logic        r_mem_we;
    logic        r_mem_acc_sz;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_rdata0;
    logic [15:0] r_rdata1;

    logic [1:0]  w_valid;
    logic [1:0]  w_legal;
    logic [1:0]  w_cand;
    logic        w_idle;
    logic        w_winner;
    logic        w_gnt_valid;
    logic        w_lock_hit;
    logic        w_grant;
    logic        w_resp_rd;
    logic [15:0] w_sel_addr;
    logic        w_sel_we;
    logic        w_sel_sz;
    logic [15:0] w_sel_wdata;
    logic        w_sel_lock;

    assign w_valid = {req1_valid, req0_valid};

    assign w_legal[0] = acc_legal(req0_we, req0_acc_sz, req0_addr[0]);
    assign w_legal[1] = acc_legal(req1_we, req1_acc_sz, req1_addr[0]);

    assign w_cand = w_valid & w_legal;
    assign w_idle = (r_state == ARB_IDLE) && !reset;

    spcpu_arb_picker u_picker (
        .i_cand      (w_cand),
        .i_last_grant(r_last_grant),
        .i_lock_act  (r_lock_left != 2'd0),
        .i_lock_idx  (r_last_grant),
        .o_winner    (w_winner),
        .o_gnt_valid (w_gnt_valid),
        .o_lock_hit  (w_lock_hit)
    );

    assign w_grant = w_idle && w_gnt_valid;

    assign w_sel_addr  = w_winner ? req1_addr   : req0_addr;
    assign w_sel_we    = w_winner ? req1_we     : req0_we;
    assign w_sel_sz    = w_winner ? req1_acc_sz : req0_acc_sz;
    assign w_sel_wdata = w_winner ? req1_wdata  : req0_wdata;
    assign w_sel_lock  = w_winner ? req1_lock   : req0_lock;

    assign req0_ready = w_grant && (w_winner == REQ_CPU);
    assign req1_ready = w_grant && (w_winner == REQ_DBG);

    assign req0_err = w_idle && w_valid[0] && !w_legal[0];
    assign req1_err = w_idle && w_valid[1] && !w_legal[1];

    assign w_resp_rd = (r_state == ARB_RESP) && !r_we && !reset;

    assign req0_rvalid = w_resp_rd && (r_owner == REQ_CPU);
    assign req1_rvalid = w_resp_rd && (r_owner == REQ_DBG);

    assign req0_rdata = req0_rvalid ? mem_rdata : r_rdata0;
    assign req1_rdata = req1_rvalid ? mem_rdata : r_rdata1;

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_acc_sz = r_mem_acc_sz;
    assign mem_wdata  = r_mem_wdata;

    // Arbiter FSM; memory bus registered so it is live only in ARB_ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_owner      <= REQ_CPU;
            r_we         <= 1'b0;
            r_last_grant <= REQ_DBG;
            r_lock_left  <= 2'd0;
            r_mem_addr   <= 16'h0000;
            r_mem_we     <= 1'b0;
            r_mem_acc_sz <= CPU_DATA_ACC_SZ_8;
            r_mem_wdata  <= 16'h0000;
        end else begin
            r_mem_addr   <= 16'h0000;
            r_mem_we     <= 1'b0;
            r_mem_acc_sz <= CPU_DATA_ACC_SZ_8;
            r_mem_wdata  <= 16'h0000;
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_gnt_valid) begin
                        r_state      <= ARB_ISSUE;
                        r_owner      <= w_winner;
                        r_we         <= w_sel_we;
                        r_last_grant <= w_winner;
                        r_mem_addr   <= w_sel_addr;
                        r_mem_we     <= w_sel_we;
                        r_mem_acc_sz <= w_sel_sz;
                        r_mem_wdata  <= w_sel_wdata;
                        if (w_lock_hit) begin
                            r_lock_left <= r_lock_left - 2'd1;
                        end else if (w_sel_lock) begin
                            r_lock_left <= LOCK_DEPTH - 2'd1;
                        end else begin
                            r_lock_left <= 2'd0;
                        end
                    end else begin
                        r_lock_left <= 2'd0;
                    end
                end
                ARB_ISSUE: r_state <= ARB_RESP;
                ARB_RESP:  r_state <= ARB_IDLE;
                default:   r_state <= ARB_IDLE;
            endcase
        end
    end

    // Read data holding registers, updated on each rvalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata0 <= 16'h0000;
            r_rdata1 <= 16'h0000;
        end else begin
            if (req0_rvalid) begin
                r_rdata0 <= mem_rdata;
            end
            if (req1_rvalid) begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_spcpu_mem_arbiter.sv
// Testbench for spcpu_mem_arbiter.
// Directed scenarios plus random traffic against a transaction model.
module tb_spcpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 0, req0_we = 0, req0_acc_sz = 0, req0_lock = 0;
    logic [15:0] req0_addr = 0, req0_wdata = 0;
    logic        req1_valid = 0, req1_we = 0, req1_acc_sz = 0, req1_lock = 0;
    logic [15:0] req1_addr = 0, req1_wdata = 0;
    logic        req0_ready, req0_rvalid, req0_err;
    logic        req1_ready, req1_rvalid, req1_err;
    logic [15:0] req0_rdata, req1_rdata;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_we, mem_acc_sz;
    logic [15:0] mem_rdata = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;

    // transaction-level model state
    int          m_phase;
    int          m_owner;
    logic        m_we, m_sz;
    logic [15:0] m_addr, m_wdata;
    int          m_lg;
    int          m_lock;
    logic [15:0] m_hold [2];
    int          cyc;
    int          g_idx [$];
    int          g_cyc [$];
    bit          memwe_seen;

    spcpu_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req0_we(req0_we), .req0_acc_sz(req0_acc_sz),
        .req0_wdata(req0_wdata), .req0_lock(req0_lock),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr),
        .req1_we(req1_we), .req1_acc_sz(req1_acc_sz),
        .req1_wdata(req1_wdata), .req1_lock(req1_lock),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_acc_sz(mem_acc_sz), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        if (a == 16'h0004) return 16'hABCD;
        return {a[7:0] ^ 8'hC3, a[15:8] + 8'h11};
    endfunction

    // memory: read data one cycle after the issue cycle
    always @(posedge clk) mem_rdata <= memfn(mem_addr);

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int n, input logic v, input logic we,
                       input logic sz, input logic [15:0] a,
                       input logic [15:0] d, input logic lk);
        if (n == 0) begin
            req0_valid = v; req0_we = we; req0_acc_sz = sz;
            req0_addr = a; req0_wdata = d; req0_lock = lk;
        end else begin
            req1_valid = v; req1_we = we; req1_acc_sz = sz;
            req1_addr = a; req1_wdata = d; req1_lock = lk;
        end
    endtask

    task automatic idle_all();
        drv(0, 0, 0, 0, 16'h0, 16'h0, 0);
        drv(1, 0, 0, 0, 16'h0, 16'h0, 0);
    endtask

    task automatic model_reset();
        m_phase = 0; m_lg = 1; m_lock = -1;
        m_hold[0] = 16'h0; m_hold[1] = 16'h0;
    endtask

    // one clock: check outputs mid-cycle, advance model, move past edge
    task automatic step();
        logic [1:0]  v, we, sz, lk, legal, cand;
        logic [15:0] ad [2];
        logic [15:0] wd [2];
        logic [1:0]  e_rdy, e_err, e_rv;
        logic [15:0] e_ma, e_mwd, e_rd0, e_rd1;
        logic        e_mwe, e_msz;
        int          w;
        bit          via;
        @(negedge clk);
        v  = {req1_valid, req0_valid};
        we = {req1_we, req0_we};
        sz = {req1_acc_sz, req0_acc_sz};
        lk = {req1_lock, req0_lock};
        ad[0] = req0_addr;  ad[1] = req1_addr;
        wd[0] = req0_wdata; wd[1] = req1_wdata;
        e_rdy = 0; e_err = 0; e_rv = 0;
        e_ma = 0; e_mwd = 0; e_mwe = 0; e_msz = 0;
        if (mem_we) memwe_seen = 1;
        if (reset) begin
            chk("rst_ready0", 16'(req0_ready), 16'h0);
            chk("rst_ready1", 16'(req1_ready), 16'h0);
            chk("rst_err0", 16'(req0_err), 16'h0);
            chk("rst_err1", 16'(req1_err), 16'h0);
            chk("rst_rvalid0", 16'(req0_rvalid), 16'h0);
            chk("rst_rvalid1", 16'(req1_rvalid), 16'h0);
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    for (int i = 0; i < 2; i++) begin
                        legal[i] = !(sz[i] && (we[i] || ad[i][0]));
                        cand[i]  = v[i] && legal[i];
                        e_err[i] = v[i] && !legal[i];
                    end
                    if (cand != 2'b00) begin
                        via = 0;
                        if (m_lock >= 0 && cand[m_lock]) begin
                            w = m_lock; via = 1;
                        end else if (cand == 2'b11) begin
                            w = (m_lg == 1) ? 0 : 1;
                        end else begin
                            w = cand[1] ? 1 : 0;
                        end
                        e_rdy[w] = 1'b1;
                        m_owner = w; m_we = we[w]; m_sz = sz[w];
                        m_addr = ad[w]; m_wdata = wd[w];
                        m_lg = w;
                        m_lock = via ? -1 : (lk[w] ? w : -1);
                        m_phase = 1;
                        g_idx.push_back(w);
                        g_cyc.push_back(cyc);
                    end else begin
                        m_lock = -1;
                    end
                end
                1: begin
                    e_ma = m_addr; e_mwe = m_we;
                    e_msz = m_sz; e_mwd = m_wdata;
                    m_phase = 2;
                end
                default: begin
                    if (!m_we) e_rv[m_owner] = 1'b1;
                    m_phase = 0;
                end
            endcase
            e_rd0 = e_rv[0] ? memfn(m_addr) : m_hold[0];
            e_rd1 = e_rv[1] ? memfn(m_addr) : m_hold[1];
            chk("ready0", 16'(req0_ready), 16'(e_rdy[0]));
            chk("ready1", 16'(req1_ready), 16'(e_rdy[1]));
            chk("err0", 16'(req0_err), 16'(e_err[0]));
            chk("err1", 16'(req1_err), 16'(e_err[1]));
            chk("rvalid0", 16'(req0_rvalid), 16'(e_rv[0]));
            chk("rvalid1", 16'(req1_rvalid), 16'(e_rv[1]));
            chk("rdata0", req0_rdata, e_rd0);
            chk("rdata1", req1_rdata, e_rd1);
            chk("mem_addr", mem_addr, e_ma);
            chk("mem_we", 16'(mem_we), 16'(e_mwe));
            chk("mem_acc_sz", 16'(mem_acc_sz), 16'(e_msz));
            chk("mem_wdata", mem_wdata, e_mwd);
            m_hold[0] = e_rd0;
            m_hold[1] = e_rd1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        g_idx.delete();
        g_cyc.delete();
    endtask

    initial begin
        model_reset();
        cyc = 0;
        memwe_seen = 0;
        #1;

        // reset, with valid requests present (reset wins)
        reset = 1;
        drv(0, 1, 0, 1, 16'h0002, 16'h0, 0);
        drv(1, 1, 0, 1, 16'h0006, 16'h0, 0);
        step(); step();
        idle_all();
        reset = 0;
        step();
        chk("post_rst_rdata0", req0_rdata, 16'h0000);
        chk("post_rst_mem_addr", mem_addr, 16'h0000);

        // single 16-bit read of 0x0004
        clear_log();
        drv(0, 1, 0, 1, 16'h0004, 16'h0, 0);
        step();
        idle_all();
        chk("rd_issue_addr", mem_addr, 16'h0004);
        chk("rd_issue_we", 16'(mem_we), 16'h0);
        step();
        chk("rd_rvalid", 16'(req0_rvalid), 16'h1);
        chk("rd_rdata", req0_rdata, 16'hABCD);
        step();
        step();
        chk("rd_hold", req0_rdata, 16'hABCD);

        // contention from reset: 0,1,0,1 every 3 cycles
        reset = 1;
        step();
        reset = 0;
        clear_log();
        drv(0, 1, 0, 1, 16'h0010, 16'h0, 0);
        drv(1, 1, 0, 0, 16'h0021, 16'h0, 0);
        repeat (12) step();
        idle_all();
        chk("cont_ngrant", 16'(g_idx.size()), 16'd4);
        if (g_idx.size() >= 4) begin
            chk("cont_g0", 16'(g_idx[0]), 16'd0);
            chk("cont_g1", 16'(g_idx[1]), 16'd1);
            chk("cont_g2", 16'(g_idx[2]), 16'd0);
            chk("cont_g3", 16'(g_idx[3]), 16'd1);
            chk("cont_gap1", 16'(g_cyc[1] - g_cyc[0]), 16'd3);
            chk("cont_gap3", 16'(g_cyc[3] - g_cyc[2]), 16'd3);
        end
        repeat (3) step();

        // lock: two req0 grants, then req1
        reset = 1;
        step();
        reset = 0;
        clear_log();
        drv(0, 1, 0, 1, 16'h0100, 16'h0, 1);
        drv(1, 1, 0, 1, 16'h0200, 16'h0, 0);
        repeat (9) step();
        idle_all();
        chk("lock_ngrant", 16'(g_idx.size()), 16'd3);
        if (g_idx.size() >= 3) begin
            chk("lock_g0", 16'(g_idx[0]), 16'd0);
            chk("lock_g1", 16'(g_idx[1]), 16'd0);
            chk("lock_g2", 16'(g_idx[2]), 16'd1);
        end
        repeat (3) step();

        // illegal 16-bit write from req1, req0 read wins same cycle
        clear_log();
        memwe_seen = 0;
        drv(1, 1, 1, 1, 16'h0010, 16'h1234, 0);
        drv(0, 1, 0, 0, 16'h0030, 16'h0, 0);
        @(negedge clk);
        chk("ill_err1", 16'(req1_err), 16'h1);
        chk("ill_ready0", 16'(req0_ready), 16'h1);
        @(posedge clk);
        #1;
        m_phase = 1; m_owner = 0; m_we = 0; m_sz = 0;
        m_addr = 16'h0030; m_wdata = 16'h0; m_lg = 0; m_lock = -1;
        cyc++;
        idle_all();
        repeat (4) step();
        chk("ill_no_memwe", 16'(memwe_seen), 16'h0);

        // byte write from req1
        drv(1, 1, 1, 0, 16'h0003, 16'h005A, 0);
        step();
        idle_all();
        chk("bw_mem_we", 16'(mem_we), 16'h1);
        chk("bw_acc_sz", 16'(mem_acc_sz), 16'h0);
        chk("bw_wdata", mem_wdata, 16'h005A);
        chk("bw_addr", mem_addr, 16'h0003);
        step();
        chk("bw_we_drop", 16'(mem_we), 16'h0);
        chk("bw_no_rvalid", 16'(req1_rvalid), 16'h0);
        step();
        step();

        // reset during issue cycle of a read
        drv(0, 1, 0, 1, 16'h0040, 16'h0, 0);
        step();
        idle_all();
        reset = 1;
        step();
        reset = 0;
        chk("mid_rvalid0", 16'(req0_rvalid), 16'h0);
        chk("mid_mem_addr", mem_addr, 16'h0000);
        chk("mid_mem_we", 16'(mem_we), 16'h0);
        chk("mid_rdata0", req0_rdata, 16'h0000);
        step();
        drv(0, 1, 0, 1, 16'h0050, 16'h0, 0);
        drv(1, 1, 0, 1, 16'h0060, 16'h0, 0);
        @(negedge clk);
        chk("mid_next_r0", 16'(req0_ready), 16'h1);
        chk("mid_next_r1", 16'(req1_ready), 16'h0);
        @(posedge clk);
        #1;
        reset = 1;
        step();
        reset = 0;
        idle_all();

        // random traffic
        for (int k = 0; k < 500; k++) begin
            reset = ($urandom_range(63) == 0);
            for (int n = 0; n < 2; n++) begin
                drv(n, 1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 16'($urandom),
                    16'($urandom), ($urandom_range(3) == 0));
            end
            step();
        end
        reset = 0;
        idle_all();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spcpu_mem_arbiter.md
SPCPU_MEM_ARBITER -- requirements
Module: spcpu_mem_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state changes on posedge clk); reset input 1 (active-high, synchronous).
REQ-002 SHALL have, per requester N in {0 = CPU, 1 = debug/loader}, these ports: reqN_valid input 1; reqN_addr input 16; reqN_we input 1; reqN_acc_sz input 1 (cpu_data_acc_sz_8/16 encoding); reqN_wdata input 16; reqN_lock input 1.
REQ-003 SHALL have, per requester N, these ports: reqN_ready output 1 (request accepted this cycle); reqN_rvalid output 1 (read data valid, one-cycle pulse); reqN_rdata output 16; reqN_err output 1 (one-cycle pulse: illegal request rejected).
REQ-004 SHALL have these memory-side ports: mem_addr output 16; mem_we output 1; mem_acc_sz output 1; mem_wdata output 16; mem_rdata input 16 (valid one cycle after the issue cycle).

Function
REQ-005 SHALL implement a three-state FSM, encoded in the package: ARB_IDLE, ARB_ISSUE, ARB_RESP.
REQ-006 In ARB_IDLE with at least one legal reqN_valid, SHALL select a winner, pulse reqN_ready for the winner only, latch its addr/we/acc_sz/wdata, and go to ARB_ISSUE.
REQ-007 Winner selection SHALL be round-robin over a last_grant bit: with both valid, the requester not granted last wins; a single valid requester wins unconditionally.
REQ-008 In ARB_ISSUE, SHALL drive mem_* from the latched request for exactly one cycle, then go to ARB_RESP; mem_we SHALL be 0 in every other state.
REQ-009 In ARB_RESP, for a read, SHALL copy mem_rdata to reqN_rdata and pulse reqN_rvalid of the owner; for a write, SHALL pulse no rvalid. Next state SHALL be ARB_IDLE.
REQ-010 Transaction latency SHALL be fixed: ready at cycle T, memory issue at T+1, rvalid at T+2, and the next grant no earlier than T+3. Sustained throughput SHALL be one access per 3 cycles.
REQ-011 A 16-bit write request (we=1, acc_sz=16) SHALL NOT be granted; SHALL pulse reqN_err in the same cycle, leave the FSM in ARB_IDLE, and allow the other requester to win that cycle.
REQ-012 A 16-bit access with addr[0]=1 SHALL be rejected the same way as REQ-011.
REQ-013 If the owner asserts reqN_lock on the request at grant time, the next grant SHALL go to that same requester, regardless of round-robin, provided it is valid in the first ARB_IDLE cycle after that grant; otherwise the lock SHALL be dropped. Lock SHALL cover at most 2 consecutive grants (32-bit instruction fetch), and the second grant SHALL NOT extend it.
REQ-014 last_grant SHALL update on every grant, including locked grants.
REQ-015 reqN_rdata SHALL hold its last value until the next rvalid for that requester.
REQ-016 Deasserting reqN_valid after ready SHALL have no effect on the in-flight transaction.

Reset
REQ-017 Reset SHALL force: state ARB_IDLE; last_grant=1 (so requester 0 wins the first contest); lock cleared; all outputs 0, including rdata and mem_acc_sz = cpu_data_acc_sz_8 encoding value 0.
REQ-018 Reset asserted during ARB_ISSUE or ARB_RESP SHALL abort the transaction, with no rvalid or err pulse in the cycle after reset.
REQ-019 Reset SHALL take priority over all other inputs in the same cycle.

Structure
REQ-020 The arbiter state enum, requester-index constants and lock-depth constant (2) SHALL live in a new package pkg_mem_arb; the access-size encoding SHALL be reused from pkg_cpu.
REQ-021 The round-robin/lock winner selection SHALL be a combinational sub-module spcpu_arb_picker (inputs: valid/legal per requester, last_grant, lock state; output: winner index and grant-valid).
REQ-022 No memory model or CPU logic SHALL reside in this module.

Verification
REQ-023 Single read: req0 read addr 0x0004, 16-bit, memory word 0xABCD -> req0_ready at T, mem_addr=0x0004 with mem_we=0 at T+1, req0_rvalid with rdata=0xABCD at T+2.
REQ-024 Contention: both requesters valid continuously after reset -> grant order 0,1,0,1, with grants at cycles T, T+3, T+6, T+9.
REQ-025 Lock: req0 with lock=1 and req1 valid throughout -> two consecutive req0 grants, then req1.
REQ-026 Illegal: req1 write, 16-bit, addr 0x0010 -> req1_err pulse, mem_we never asserted, and req0 (valid in the same cycle) granted.
REQ-027 Byte write: req1 write, 8-bit, addr 0x0003, data 0x005A -> mem_we=1, mem_acc_sz=8, mem_wdata=0x005A for one cycle, no rvalid.
REQ-028 Reset mid-transaction: reset asserted at T+1 of a read -> no rvalid, all outputs 0 after reset, and the next contest won by req0.
